// File: rtl/dff_unlink_4_8bits_if.sv
// dff_unlink_4_8bits_if
//   Bundles the load (word-wide) and drain (byte-wide) handshakes of the
//   DFF unlink block.
//   word_in/load_valid/load_ready : parallel-load handshake (producer -> block)
//   output_data/out_valid/out_ready : byte stream handshake (block -> consumer)
//   remaining : bytes still held by the block, including the head byte
//   modport slave  : the unlink block itself
//   modport master : the environment driving loads and consuming bytes
interface dff_unlink_4_8bits_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int RW = $clog2(DEPTH + 1);

  logic [WIDTH*DEPTH-1:0] word_in;
  logic                   load_valid;
  logic                   load_ready;
  logic [WIDTH-1:0]       output_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [RW-1:0]          remaining;

  modport slave (
    input  word_in, load_valid, out_ready,
    output load_ready, output_data, out_valid, remaining
  );

  modport master (
    output word_in, load_valid, out_ready,
    input  load_ready, output_data, out_valid, remaining
  );
endinterface

// File: rtl/dff_unlink_4_8bits.sv
// dff_unlink_4_8bits
//   Receive end of the DFF link path. A single load handshake captures DEPTH
//   bytes into a stage chain; the chain then shifts out one byte per accepted
//   output handshake. output_data is stage[0] straight from a register.
//   Ports:
//     clk_i : clock, all state on posedge
//     rst_i : synchronous active-high reset
//     bus   : dff_unlink_4_8bits_if.slave (load and byte-stream handshakes)
//   Parameters: WIDTH (bits per byte), DEPTH (stages, >= 2),
//     MSB_FIRST (0: lowest slice of word_in emitted first, 1: top slice first)
//   Optional feature macro: DFF_UNLINK_BACKTOBACK_EN
//     When defined, a new word may be loaded in the same cycle the last byte
//     of the current word is accepted, giving a bubble-free byte stream.
//     This adds a combinational path out_ready -> load_ready.
module dff_unlink_4_8bits #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dff_unlink_4_8bits_if.slave   bus
);
  localparam int RW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]   stage_q, stage_d;
  logic [DEPTH-1:0][WIDTH-1:0]   load_stages;
  logic [RW-1:0]                 rem_q, rem_d;
  logic                          load_fire, out_fire, last;

  // Slice the incoming word into stage order; stage[0] is emitted first.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    if (MSB_FIRST) begin : g_msb
      assign load_stages[i] = bus.word_in[(DEPTH-1-i)*WIDTH +: WIDTH];
    end else begin : g_lsb
      assign load_stages[i] = bus.word_in[i*WIDTH +: WIDTH];
    end
  end

  assign last            = (rem_q == RW'(1));
  assign bus.out_valid   = (state_q == DRAIN);
  assign bus.output_data = stage_q[0];
  assign bus.remaining   = rem_q;

`ifdef DFF_UNLINK_BACKTOBACK_EN
  assign bus.load_ready  = (state_q == IDLE) ||
                           ((state_q == DRAIN) && last && bus.out_ready);
`else
  assign bus.load_ready  = (state_q == IDLE);
`endif

  assign load_fire = bus.load_valid && bus.load_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (load_fire) begin
          stage_d = load_stages;
          rem_d   = RW'(DEPTH);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          for (int i = 0; i < DEPTH-1; i++) stage_d[i] = stage_q[i+1];
          stage_d[DEPTH-1] = '0;
          if (rem_q != '0) rem_d = rem_q - RW'(1);
          if (last) begin
            // Word finished: park with a cleared head so output_data reads 0.
            state_d = IDLE;
            stage_d = '0;
            rem_d   = '0;
          end
          // load_fire in DRAIN is only possible on the final handshake.
          if (load_fire) begin
            stage_d = load_stages;
            rem_d   = RW'(DEPTH);
            state_d = DRAIN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      stage_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      rem_q   <= rem_d;
    end
  end
endmodule

// File: tb/tb_dff_unlink_4_8bits.sv
// tb_dff_unlink_4_8bits
//   Directed table of per-cycle {inputs, expected outputs} for the LSB-first
//   instance, plus a hand-written MSB-first sequence on a second instance.
//   Inputs change on the falling edge; outputs are sampled 1 ns later, so each
//   row's expectations describe the cycle before the next rising edge.
module tb_dff_unlink_4_8bits;
`ifdef DFF_UNLINK_BACKTOBACK_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dff_unlink_4_8bits_if #(.WIDTH(8), .DEPTH(4)) bus0 ();
  dff_unlink_4_8bits_if #(.WIDTH(8), .DEPTH(4)) bus1 ();

  dff_unlink_4_8bits #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_i(rst), .bus(bus0));
  dff_unlink_4_8bits #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_i(rst), .bus(bus1));

  typedef struct {
    logic        rst;
    logic        lv;
    logic        ordy;
    logic [31:0] w;
    logic        ov;
    logic        lr;
    logic [7:0]  d;
    logic [2:0]  rem;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic r, input logic lv, input logic ordy,
                     input logic [31:0] w, input logic ov, input logic lr,
                     input logic [7:0] d, input logic [2:0] rem);
    vec_t v;
    v.rst = r; v.lv = lv; v.ordy = ordy; v.w = w;
    v.ov = ov; v.lr = lr; v.d = d; v.rem = rem;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Advance one full cycle, landing on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Idle-state row helper: no load, consumer ready.
  task automatic add_idle(input logic r);
    add(r, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 8'h00, 3'd0);
  endtask

  task automatic add_load(input logic [31:0] w);
    add(1'b0, 1'b1, 1'b1, w, 1'b0, 1'b1, 8'h00, 3'd0);
  endtask

  task automatic build_table();
    // 1: plain drain with consumer always ready
    add_load(32'h44332211);
    add(0, 0, 1, 0, 1, 0,   8'h11, 3'd4);
    add(0, 0, 1, 0, 1, 0,   8'h22, 3'd3);
    add(0, 0, 1, 0, 1, 0,   8'h33, 3'd2);
    add(0, 0, 1, 0, 1, BTB, 8'h44, 3'd1);
    add_idle(0);
    // 2: consumer stalls 3 cycles on the head byte
    add_load(32'h44332211);
    add(0, 0, 0, 0, 1, 0,   8'h11, 3'd4);
    add(0, 0, 0, 0, 1, 0,   8'h11, 3'd4);
    add(0, 0, 0, 0, 1, 0,   8'h11, 3'd4);
    add(0, 0, 1, 0, 1, 0,   8'h11, 3'd4);
    add(0, 0, 1, 0, 1, 0,   8'h22, 3'd3);
    add(0, 0, 1, 0, 1, 0,   8'h33, 3'd2);
    add(0, 0, 0, 0, 1, 0,   8'h44, 3'd1);  // stall on last byte too
    add(0, 0, 1, 0, 1, BTB, 8'h44, 3'd1);
    add_idle(0);
    // 4: load offered during DRAIN is refused and not captured
    add_load(32'h44332211);
    add(0, 1, 1, 32'hDEADBEEF, 1, 0,   8'h11, 3'd4);
    add(0, 1, 1, 32'hDEADBEEF, 1, 0,   8'h22, 3'd3);
    add(0, 1, 1, 32'hDEADBEEF, 1, 0,   8'h33, 3'd2);
    add(0, 0, 1, 0,            1, BTB, 8'h44, 3'd1);
    add_idle(0);
    // 5: reset right after byte 22 is accepted discards the rest
    add_load(32'h44332211);
    add(0, 0, 1, 0, 1, 0, 8'h11, 3'd4);
    add(0, 0, 1, 0, 1, 0, 8'h22, 3'd3);
    add(1, 0, 1, 0, 1, 0, 8'h33, 3'd2);
    add_idle(0);
    add_idle(0);
    // reset wins over a simultaneous load
    add(1, 1, 1, 32'hCAFEF00D, 0, 1, 8'h00, 3'd0);
    add_idle(0);
    // 6: two words offered back to back
    add_load(32'h44332211);
    add(0, 0, 1, 0, 1, 0, 8'h11, 3'd4);
    add(0, 0, 1, 0, 1, 0, 8'h22, 3'd3);
    add(0, 0, 1, 0, 1, 0, 8'h33, 3'd2);
    add(0, 1, 1, 32'h88776655, 1, BTB, 8'h44, 3'd1);
    if (!BTB) add_load(32'h88776655);  // one bubble cycle
    add(0, 0, 1, 0, 1, 0, 8'h55, 3'd4);
    add(0, 0, 1, 0, 1, 0, 8'h66, 3'd3);
    add(0, 0, 1, 0, 1, 0, 8'h77, 3'd2);
    add(0, 0, 1, 0, 1, BTB, 8'h88, 3'd1);
    add_idle(0);
  endtask

  initial begin
    rst = 1'b1;
    bus0.word_in = '0; bus0.load_valid = 1'b0; bus0.out_ready = 1'b1;
    bus1.word_in = '0; bus1.load_valid = 1'b0; bus1.out_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_ov",   0, 32'(bus0.out_valid),   32'h0);
    chk("rst_lr",   0, 32'(bus0.load_ready),  32'h1);
    chk("rst_data", 0, 32'(bus0.output_data), 32'h0);
    chk("rst_rem",  0, 32'(bus0.remaining),   32'h0);
    chk("rst_ov_msb", 0, 32'(bus1.out_valid), 32'h0);
    @(negedge clk);

    build_table();
    foreach (vecs[i]) begin
      rst              = vecs[i].rst;
      bus0.load_valid  = vecs[i].lv;
      bus0.out_ready   = vecs[i].ordy;
      bus0.word_in     = vecs[i].w;
      #1;
      chk("out_valid",   i, 32'(bus0.out_valid),   32'(vecs[i].ov));
      chk("load_ready",  i, 32'(bus0.load_ready),  32'(vecs[i].lr));
      chk("output_data", i, 32'(bus0.output_data), 32'(vecs[i].d));
      chk("remaining",   i, 32'(bus0.remaining),   32'(vecs[i].rem));
      step();
    end
    rst = 1'b0;
    bus0.load_valid = 1'b0;

    // 3: MSB-first instance emits the top slice first
    begin
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
      bus1.word_in = 32'h44332211; bus1.load_valid = 1'b1; bus1.out_ready = 1'b1;
      #1;
      chk("msb_lr", 0, 32'(bus1.load_ready), 32'h1);
      step();
      bus1.load_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        #1;
        chk("msb_ov",   k, 32'(bus1.out_valid),   32'h1);
        chk("msb_data", k, 32'(bus1.output_data), 32'(exp_b[k]));
        chk("msb_rem",  k, 32'(bus1.remaining),   32'(4 - k));
        step();
      end
      #1;
      chk("msb_end_ov",   0, 32'(bus1.out_valid),   32'h0);
      chk("msb_end_data", 0, 32'(bus1.output_data), 32'h0);
      chk("msb_end_lr",   0, 32'(bus1.load_ready),  32'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
